// File: rtl/hazard_unit_mc_if.sv
// rtl/hazard_unit_mc_if.sv - pipeline-side bundle for the hazard/forwarding controller
interface hazard_unit_mc_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    // pipeline status presented to the hazard unit
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_need;
    logic                     id_is_md;
    logic                     id_rd_hilo;
    logic [NUM_SRC*REG_W-1:0] ex_src;
    logic [NUM_SRC-1:0]       ex_src_need;
    logic [REG_W-1:0]         ex_dst;
    logic                     ex_wr;
    logic                     ex_is_load;
    logic [REG_W-1:0]         mem_dst;
    logic                     mem_wr;
    logic                     mem_is_load;
    logic                     mem_req;
    logic                     dmem_ready;
    logic [REG_W-1:0]         wb_dst;
    logic                     wb_wr;
    logic                     cnt_clr;

    // pipeline control returned by the hazard unit
    logic [2*NUM_SRC-1:0]     ex_fwd_sel;
    logic                     if_stall;
    logic                     id_stall;
    logic                     ex_stall;
    logic                     mem_stall;
    logic                     ex_flush;
    logic                     wb_bubble;
    logic                     md_busy;
    logic [CNT_W-1:0]         cnt_load;
    logic [CNT_W-1:0]         cnt_mem;
    logic [CNT_W-1:0]         cnt_md;

    modport master (
        output id_src, id_src_need, id_is_md, id_rd_hilo,
        output ex_src, ex_src_need, ex_dst, ex_wr, ex_is_load,
        output mem_dst, mem_wr, mem_is_load, mem_req, dmem_ready,
        output wb_dst, wb_wr, cnt_clr,
        input  ex_fwd_sel, if_stall, id_stall, ex_stall, mem_stall,
        input  ex_flush, wb_bubble, md_busy, cnt_load, cnt_mem, cnt_md
    );

    modport slave (
        input  id_src, id_src_need, id_is_md, id_rd_hilo,
        input  ex_src, ex_src_need, ex_dst, ex_wr, ex_is_load,
        input  mem_dst, mem_wr, mem_is_load, mem_req, dmem_ready,
        input  wb_dst, wb_wr, cnt_clr,
        output ex_fwd_sel, if_stall, id_stall, ex_stall, mem_stall,
        output ex_flush, wb_bubble, md_busy, cnt_load, cnt_mem, cnt_md
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - 5-stage hazard/forwarding controller with dmem wait, MUL/DIV tracking and stall counters
module hazard_unit_mc #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int MD_LAT  = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_unit_mc_if.slave   hif
);
    localparam int MD_W = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MD_W-1:0]      md_cnt;
    logic [2*NUM_SRC-1:0] fwd;
    logic                 mem_wait;
    logic                 load_use;
    logic                 md_haz;
    logic                 id_hold;
    logic [CNT_W-1:0]     cnt_load_q;
    logic [CNT_W-1:0]     cnt_mem_q;
    logic [CNT_W-1:0]     cnt_md_q;

    assign mem_wait = hif.mem_req & ~hif.dmem_ready;
    assign md_haz   = (md_cnt != '0) & (hif.id_is_md | hif.id_rd_hilo);
    assign id_hold  = mem_wait | load_use | md_haz;

    // EX operand forwarding: MEM (non-load) beats WB; $0 never forwards
    always_comb begin
        logic [REG_W-1:0] src;
        fwd = '0;
        src = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = hif.ex_src[i*REG_W +: REG_W];
            if (hif.ex_src_need[i] && src != '0) begin
                if (hif.mem_wr && !hif.mem_is_load && hif.mem_dst == src)
                    fwd[2*i +: 2] = 2'b01;
                else if (hif.wb_wr && hif.wb_dst == src)
                    fwd[2*i +: 2] = 2'b10;
            end
        end
    end

    // load-use: any read ID operand matches the non-zero destination of a load in EX
    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hif.id_src_need[i] && hif.ex_dst != '0 &&
                hif.id_src[i*REG_W +: REG_W] == hif.ex_dst)
                load_use = 1'b1;
        end
        load_use = load_use & hif.ex_is_load & hif.ex_wr;
    end

    // stage control: reset forces a full freeze, dmem wait holds IF..MEM, otherwise bubble into EX
    always_comb begin
        hif.ex_fwd_sel = fwd;
        hif.if_stall   = 1'b0;
        hif.id_stall   = 1'b0;
        hif.ex_stall   = 1'b0;
        hif.mem_stall  = 1'b0;
        hif.ex_flush   = 1'b0;
        hif.wb_bubble  = 1'b0;
        if (!rst_n) begin
            hif.ex_fwd_sel = '0;
            hif.if_stall   = 1'b1;
            hif.id_stall   = 1'b1;
            hif.ex_stall   = 1'b1;
            hif.mem_stall  = 1'b1;
            hif.wb_bubble  = 1'b1;
        end else if (mem_wait) begin
            hif.if_stall   = 1'b1;
            hif.id_stall   = 1'b1;
            hif.ex_stall   = 1'b1;
            hif.mem_stall  = 1'b1;
            hif.wb_bubble  = 1'b1;
        end else if (load_use || md_haz) begin
            hif.if_stall   = 1'b1;
            hif.id_stall   = 1'b1;
            hif.ex_flush   = 1'b1;
        end
    end

    // MUL/DIV countdown: reload when an MD op leaves ID, otherwise run down to zero (ignores dmem wait)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_cnt <= '0;
        else if (hif.id_is_md && !id_hold)
            md_cnt <= MD_W'(MD_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - MD_W'(1);
    end

    assign hif.md_busy = (md_cnt != '0);

    // one saturating counter per stall cause, highest-priority cause only; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_load_q <= '0;
            cnt_mem_q  <= '0;
            cnt_md_q   <= '0;
        end else if (hif.cnt_clr) begin
            cnt_load_q <= '0;
            cnt_mem_q  <= '0;
            cnt_md_q   <= '0;
        end else if (mem_wait) begin
            if (cnt_mem_q != CNT_MAX)
                cnt_mem_q <= cnt_mem_q + CNT_W'(1);
        end else if (load_use) begin
            if (cnt_load_q != CNT_MAX)
                cnt_load_q <= cnt_load_q + CNT_W'(1);
        end else if (md_haz) begin
            if (cnt_md_q != CNT_MAX)
                cnt_md_q <= cnt_md_q + CNT_W'(1);
        end
    end

    assign hif.cnt_load = cnt_load_q;
    assign hif.cnt_mem  = cnt_mem_q;
    assign hif.cnt_md   = cnt_md_q;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;
    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int MD_LAT  = 8;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hif ();

    hazard_unit_mc #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    typedef struct {
        string      name;
        logic [3:0] fwd;
        logic [5:0] ctl;
    } exp_t;

    typedef struct {
        logic [9:0] id_src;
        logic [1:0] id_need;
        logic [9:0] ex_src;
        logic [1:0] ex_need;
        logic [4:0] ex_dst;
        logic       ex_wr;
        logic       ex_is_load;
        logic [4:0] mem_dst;
        logic       mem_wr;
        logic       mem_is_load;
        logic       mem_req;
        logic       dmem_ready;
        logic [4:0] wb_dst;
        logic       wb_wr;
        logic [3:0] fwd;
        logic [5:0] ctl;
    } vec_t;

    // ctl = {if_stall, id_stall, ex_stall, mem_stall, ex_flush, wb_bubble}
    localparam logic [5:0] C_RUN  = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_MEMW = 6'b111101;
    localparam logic [5:0] C_RST  = 6'b111101;

    exp_t exp_q[$];
    vec_t vt[16];

    task automatic idle();
        hif.id_src = '0;      hif.id_src_need = '0;  hif.id_is_md = 1'b0;  hif.id_rd_hilo = 1'b0;
        hif.ex_src = '0;      hif.ex_src_need = '0;  hif.ex_dst = '0;      hif.ex_wr = 1'b0;
        hif.ex_is_load = 1'b0;
        hif.mem_dst = '0;     hif.mem_wr = 1'b0;     hif.mem_is_load = 1'b0;
        hif.mem_req = 1'b0;   hif.dmem_ready = 1'b0;
        hif.wb_dst = '0;      hif.wb_wr = 1'b0;      hif.cnt_clr = 1'b0;
    endtask

    task automatic push(input string name, input logic [3:0] fwd, input logic [5:0] ctl);
        exp_t e;
        e.name = name;
        e.fwd  = fwd;
        e.ctl  = ctl;
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t       e;
        logic [5:0] ctl;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hif.ex_src_need[i] && hif.mem_wr && hif.mem_is_load &&
                hif.ex_src[i*REG_W +: REG_W] != '0 && hif.mem_dst == hif.ex_src[i*REG_W +: REG_W]) begin
                fails++;
                $display("FAIL mem_load_fwd: operand %0d sees a load in MEM, required none", i);
            end
        end
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got nothing, required an entry");
        end else begin
            e   = exp_q.pop_front();
            ctl = {hif.if_stall, hif.id_stall, hif.ex_stall, hif.mem_stall, hif.ex_flush, hif.wb_bubble};
            tests++;
            if (hif.ex_fwd_sel !== e.fwd || ctl !== e.ctl) begin
                fails++;
                $display("FAIL %s: fwd=%b ctl=%b, required fwd=%b ctl=%b", e.name, hif.ex_fwd_sel, ctl, e.fwd, e.ctl);
            end
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // inputs already driven this low phase: compare combinational outputs, then cross one rising edge
    task automatic step(input string name, input logic [3:0] fwd, input logic [5:0] ctl);
        push(name, fwd, ctl);
        #1;
        check_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        idle();
        hif.cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        hif.cnt_clr = 1'b0;
    endtask

    task automatic load_use_in();
        hif.ex_is_load = 1'b1; hif.ex_wr = 1'b1; hif.ex_dst = 5'd5;
        hif.id_src = {5'd0, 5'd5}; hif.id_src_need = 2'b01;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        // id_src id_need ex_src ex_need ex_dst ex_wr ex_ld mem_dst mem_wr mem_ld mem_req dready wb_dst wb_wr fwd ctl
        vt[0]  = '{10'd0, 2'b00, {5'd0, 5'd3}, 2'b01, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 4'b0001, C_RUN};
        vt[1]  = '{10'd0, 2'b00, {5'd0, 5'd3}, 2'b01, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 4'b0010, C_RUN};
        vt[2]  = '{10'd0, 2'b00, {5'd0, 5'd0}, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'b0000, C_RUN};
        vt[3]  = '{10'd0, 2'b00, {5'd7, 5'd0}, 2'b10, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 4'b1000, C_RUN};
        vt[4]  = '{10'd0, 2'b00, {5'd7, 5'd0}, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 4'b0000, C_RUN};
        vt[5]  = '{10'd0, 2'b00, {5'd6, 5'd4}, 2'b11, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 4'b1001, C_RUN};
        vt[6]  = '{10'd0, 2'b00, {5'd9, 5'd9}, 2'b11, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 4'b0101, C_RUN};
        vt[7]  = '{{5'd0, 5'd5}, 2'b01, 10'd0, 2'b00, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, C_LU};
        vt[8]  = '{{5'd0, 5'd5}, 2'b00, 10'd0, 2'b00, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, C_RUN};
        vt[9]  = '{{5'd0, 5'd0}, 2'b01, 10'd0, 2'b00, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, C_RUN};
        vt[10] = '{{5'd0, 5'd5}, 2'b01, 10'd0, 2'b00, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, C_RUN};
        vt[11] = '{{5'd5, 5'd0}, 2'b10, 10'd0, 2'b00, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, C_LU};
        vt[12] = '{10'd0, 2'b00, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0000, C_MEMW};
        vt[13] = '{10'd0, 2'b00, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0000, C_RUN};
        vt[14] = '{{5'd0, 5'd5}, 2'b01, 10'd0, 2'b00, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0000, C_MEMW};
        vt[15] = '{{5'd0, 5'd6}, 2'b01, 10'd0, 2'b00, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, C_RUN};

        // reset: outputs forced even with a live forwarding match
        rst_n = 1'b0;
        idle();
        hif.ex_src = {5'd0, 5'd3}; hif.ex_src_need = 2'b01; hif.mem_dst = 5'd3; hif.mem_wr = 1'b1;
        #2;
        push("reset_forced", 4'b0000, C_RST);
        check_pop();
        check_val("reset_md_busy", int'(hif.md_busy), 0);
        check_val("reset_cnt_load", int'(hif.cnt_load), 0);
        check_val("reset_cnt_mem", int'(hif.cnt_mem), 0);
        check_val("reset_cnt_md", int'(hif.cnt_md), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // combinational vector table
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            idle();
            hif.id_src = vt[k].id_src;       hif.id_src_need = vt[k].id_need;
            hif.ex_src = vt[k].ex_src;       hif.ex_src_need = vt[k].ex_need;
            hif.ex_dst = vt[k].ex_dst;       hif.ex_wr = vt[k].ex_wr;        hif.ex_is_load = vt[k].ex_is_load;
            hif.mem_dst = vt[k].mem_dst;     hif.mem_wr = vt[k].mem_wr;      hif.mem_is_load = vt[k].mem_is_load;
            hif.mem_req = vt[k].mem_req;     hif.dmem_ready = vt[k].dmem_ready;
            hif.wb_dst = vt[k].wb_dst;       hif.wb_wr = vt[k].wb_wr;
            step($sformatf("vec%0d", k), vt[k].fwd, vt[k].ctl);
        end
        check_val("table_cnt_load", int'(hif.cnt_load), 2);
        check_val("table_cnt_mem", int'(hif.cnt_mem), 2);
        check_val("table_cnt_md", int'(hif.cnt_md), 0);
        clear_cnt();
        check_val("clr_cnt_load", int'(hif.cnt_load), 0);
        check_val("clr_cnt_mem", int'(hif.cnt_mem), 0);

        // load-use stall, bubble, then forward from WB
        @(negedge clk); idle(); load_use_in();
        step("lu_stall", 4'b0000, C_LU);
        check_val("lu_cnt_load", int'(hif.cnt_load), 1);
        @(negedge clk); idle();
        hif.id_src = {5'd0, 5'd5}; hif.id_src_need = 2'b01;
        hif.mem_dst = 5'd5; hif.mem_wr = 1'b1; hif.mem_is_load = 1'b1;
        step("lu_bubble", 4'b0000, C_RUN);
        @(negedge clk); idle();
        hif.ex_src = {5'd0, 5'd5}; hif.ex_src_need = 2'b01; hif.wb_dst = 5'd5; hif.wb_wr = 1'b1;
        step("lu_fwd_wb", 4'b0010, C_RUN);
        check_val("lu_cnt_load_hold", int'(hif.cnt_load), 1);

        // dmem wait over a pending load-use: only the memory cause counts
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); load_use_in();
            hif.mem_req = 1'b1;
            step($sformatf("mw_lu%0d", k), 4'b0000, C_MEMW);
        end
        check_val("mw_cnt_mem", int'(hif.cnt_mem), 3);
        check_val("mw_cnt_load", int'(hif.cnt_load), 1);
        @(negedge clk); idle(); load_use_in();
        hif.mem_req = 1'b1; hif.dmem_ready = 1'b1;
        step("mw_release_lu", 4'b0000, C_LU);
        check_val("mw_cnt_load2", int'(hif.cnt_load), 2);

        // clear beats a same-cycle increment
        @(negedge clk); idle(); load_use_in();
        hif.cnt_clr = 1'b1;
        step("clr_vs_inc", 4'b0000, C_LU);
        check_val("clr_inc_load", int'(hif.cnt_load), 0);
        check_val("clr_inc_mem", int'(hif.cnt_mem), 0);

        // MULT then MFLO: eight stall cycles
        @(negedge clk); idle(); hif.id_is_md = 1'b1;
        step("md_issue", 4'b0000, C_RUN);
        check_val("md_busy_after_issue", int'(hif.md_busy), 1);
        for (int k = 0; k < MD_LAT; k++) begin
            @(negedge clk); idle(); hif.id_rd_hilo = 1'b1;
            step($sformatf("mflo_wait%0d", k), 4'b0000, C_LU);
        end
        check_val("md_busy_fall", int'(hif.md_busy), 0);
        check_val("md_cnt_md", int'(hif.cnt_md), MD_LAT);
        @(negedge clk); idle(); hif.id_rd_hilo = 1'b1;
        step("mflo_go", 4'b0000, C_RUN);
        clear_cnt();

        // back-to-back MULT
        @(negedge clk); idle(); hif.id_is_md = 1'b1;
        step("md2_issue", 4'b0000, C_RUN);
        for (int k = 0; k < MD_LAT; k++) begin
            @(negedge clk); idle(); hif.id_is_md = 1'b1;
            step($sformatf("md2_wait%0d", k), 4'b0000, C_LU);
        end
        check_val("md2_cnt_md", int'(hif.cnt_md), MD_LAT);
        @(negedge clk); idle(); hif.id_is_md = 1'b1;
        step("md2_go", 4'b0000, C_RUN);
        check_val("md2_busy_again", int'(hif.md_busy), 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle();
            step($sformatf("md2_idle%0d", k), 4'b0000, C_RUN);
        end
        check_val("md2_busy_mid", int'(hif.md_busy), 1);

        // reset in the middle of a MUL/DIV
        @(negedge clk); idle();
        hif.ex_src = {5'd0, 5'd3}; hif.ex_src_need = 2'b01; hif.wb_dst = 5'd3; hif.wb_wr = 1'b1;
        rst_n = 1'b0;
        #1;
        push("rst_mid_forced", 4'b0000, C_RST);
        check_pop();
        check_val("rst_mid_md_busy", int'(hif.md_busy), 0);
        check_val("rst_mid_cnt_md", int'(hif.cnt_md), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); hif.id_rd_hilo = 1'b1;
        step("rst_mflo_go", 4'b0000, C_RUN);
        check_val("rst_md_busy_after", int'(hif.md_busy), 0);

        // saturation
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); idle(); hif.mem_req = 1'b1;
            step($sformatf("sat%0d", k), 4'b0000, C_MEMW);
        end
        check_val("sat_cnt_mem", int'(hif.cnt_mem), 15);
        check_val("sat_cnt_load", int'(hif.cnt_load), 0);
        clear_cnt();
        check_val("sat_clr", int'(hif.cnt_mem), 0);

        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
